// File: rtl/prra_lut_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prra_lut_core : next-grant lookup for a priority round-robin arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prra_lut_core #(
  parameter int WIDTH           = 4,
  parameter int LOG2_WIDTH      = 2,
  parameter int STATE_OFFSET    = 0,
  parameter int REGISTER_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [WIDTH-1:0]      request,
  output logic [LOG2_WIDTH-1:0] state
);

  logic [2*WIDTH-1:0]    w_dbl;
  logic [WIDTH-1:0]      w_rot;
  logic [LOG2_WIDTH-1:0] next_d;

  // Bit j of w_rot is request[(STATE_OFFSET+1+j) mod WIDTH]: search order starts after owner.
  assign w_dbl = {request, request};
  assign w_rot = w_dbl[STATE_OFFSET+1 +: WIDTH];

  always_comb begin
    next_d = LOG2_WIDTH'(STATE_OFFSET);
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (w_rot[j]) next_d = LOG2_WIDTH'((STATE_OFFSET + 1 + j) % WIDTH);
    end
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg
      logic [LOG2_WIDTH-1:0] state_q;

      always_ff @(posedge clk) begin
        if (srst) state_q <= LOG2_WIDTH'(STATE_OFFSET);
        else      state_q <= next_d;
      end

      assign state = state_q;
    end else begin : g_comb
      logic w_unused_clk_srst;
      assign w_unused_clk_srst = &{1'b0, clk, srst};
      assign state = next_d;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prra_lut_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_prra_lut_core : self-checking bench for prra_lut_core             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_prra_lut_core;

  logic       clk;
  logic       srst;
  logic [3:0] req4;
  logic [2:0] req3;
  logic [3:0] req_r;
  logic       ring_rst;
  logic [1:0] c4_state [4];
  logic [1:0] c3_state [3];
  logic [1:0] r_state;
  logic [1:0] ring_q;

  int checks;
  int errors;
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_c4
      prra_lut_core #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(k), .REGISTER_OUTPUT(0)) u_dut (
        .clk(clk), .srst(srst), .request(req4), .state(c4_state[k]));
    end
    for (genvar k = 0; k < 3; k++) begin : g_c3
      prra_lut_core #(.WIDTH(3), .LOG2_WIDTH(2), .STATE_OFFSET(k), .REGISTER_OUTPUT(0)) u_dut (
        .clk(clk), .srst(srst), .request(req3), .state(c3_state[k]));
    end
  endgenerate

  prra_lut_core #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(1), .REGISTER_OUTPUT(1)) u_reg (
    .clk(clk), .srst(srst), .request(req_r), .state(r_state));

  // Arbiter integration: registered owner selects which instance's answer is used next.
  always_ff @(posedge clk) begin
    if (ring_rst) ring_q <= 2'd0;
    else          ring_q <= c4_state[ring_q];
  end

  function automatic int model(int req, int off, int w);
    int r;
    r = off;
    for (int k = w; k >= 1; k--) begin
      if (((req >> ((off + k) % w)) & 1) != 0) r = (off + k) % w;
    end
    return r;
  endfunction

  task automatic test_reset();
    int e;
    int got;
    srst  = 1'b1;
    req_r = 4'b0001;
    exp_q.push_back(1);
    repeat (2) @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = int'(r_state);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", got, e);
    end
  endtask

  task automatic test_directed4();
    int offs [8] = '{0, 0, 0, 2, 2, 2, 3, 3};
    int reqs [8] = '{4'b0000, 4'b0001, 4'b1111, 4'b0011, 4'b1000, 4'b0100, 4'b1010, 4'b1000};
    int exps [8] = '{0, 0, 1, 0, 3, 2, 1, 3};
    int e;
    int got;
    for (int i = 0; i < 8; i++) begin
      req4 = 4'(reqs[i]);
      exp_q.push_back(exps[i]);
      #1;
      e   = exp_q.pop_front();
      got = int'(c4_state[offs[i]]);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL directed4 off=%0d req=%b got %0d exp %0d", offs[i], req4, got, e);
      end
    end
  endtask

  task automatic test_directed3();
    int reqs [2] = '{3'b010, 3'b100};
    int exps [2] = '{1, 2};
    int e;
    int got;
    for (int i = 0; i < 2; i++) begin
      req3 = 3'(reqs[i]);
      exp_q.push_back(exps[i]);
      #1;
      e   = exp_q.pop_front();
      got = int'(c3_state[2]);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL directed3 req=%b got %0d exp %0d", req3, got, e);
      end
    end
  endtask

  task automatic test_sweep();
    int e;
    int got;
    for (int r = 0; r < 16; r++) begin
      req4 = 4'(r);
      for (int o = 0; o < 4; o++) exp_q.push_back(model(r, o, 4));
      #1;
      for (int o = 0; o < 4; o++) begin
        e   = exp_q.pop_front();
        got = int'(c4_state[o]);
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL sweep4 off=%0d req=%b got %0d exp %0d", o, req4, got, e);
        end
      end
    end
    for (int r = 0; r < 8; r++) begin
      req3 = 3'(r);
      for (int o = 0; o < 3; o++) exp_q.push_back(model(r, o, 3));
      #1;
      for (int o = 0; o < 3; o++) begin
        e   = exp_q.pop_front();
        got = int'(c3_state[o]);
        checks++;
        if (got !== e || got >= 3) begin
          errors++;
          $display("FAIL sweep3 off=%0d req=%b got %0d exp %0d", o, req3, got, e);
        end
      end
    end
  endtask

  task automatic test_registered();
    int e;
    int got;
    srst  = 1'b0;
    req_r = 4'b0001;
    exp_q.push_back(0);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = int'(r_state);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reg_release got %0d exp %0d", got, e);
    end
    srst = 1'b1;
    exp_q.push_back(1);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = int'(r_state);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reg_srst_priority got %0d exp %0d", got, e);
    end
    srst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e;
    int got;
    int r;
    for (int i = 0; i < 40; i++) begin
      r     = int'($urandom_range(0, 15));
      req_r = 4'(r);
      exp_q.push_back(model(r, 1, 4));
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      got = int'(r_state);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back req=%b got %0d exp %0d", req_r, got, e);
      end
    end
  endtask

  task automatic run_ring(input logic [3:0] rq, input string tag,
                          input int s0, input int s1, input int s2);
    int seq [3];
    int e;
    int got;
    int len;
    seq[0] = s0; seq[1] = s1; seq[2] = s2;
    len = (s2 < 0) ? 2 : 3;
    req4     = rq;
    ring_rst = 1'b1;
    @(posedge clk);
    #1;
    ring_rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(seq[i % len]);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      e   = exp_q.pop_front();
      got = int'(ring_q);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s step=%0d got %0d exp %0d", tag, i, got, e);
      end
    end
  endtask

  task automatic test_ring();
    int e;
    int got;
    int four [4] = '{0, 1, 2, 3};
    req4     = 4'b1111;
    ring_rst = 1'b1;
    @(posedge clk);
    #1;
    ring_rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(four[i % 4]);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      e   = exp_q.pop_front();
      got = int'(ring_q);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ring_all step=%0d got %0d exp %0d", i, got, e);
      end
    end
    run_ring(4'b1011, "ring_drop2", 0, 1, 3);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    srst     = 1'b1;
    ring_rst = 1'b1;
    req4     = 4'b0000;
    req3     = 3'b000;
    req_r    = 4'b0000;
    test_reset();
    test_registered();
    test_directed4();
    test_directed3();
    test_sweep();
    test_back_to_back();
    test_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prra_lut_core.md
Name: prra_lut_core

Overview:
Next-grant lookup for a priority round-robin arbiter (PRRA). Given the request vector and a fixed current-owner index (STATE_OFFSET), it returns the index of the next port to serve. It searches the requests in circular order, starting just after the current owner. The shared-memory multiport interface instantiates one per port (STATE_OFFSET = 0..N-1) and muxes the outputs with its registered state.

Parameters:
WIDTH, 4, number of requesters (>= 2; need not be a power of two)
LOG2_WIDTH, 2, width of the state index; must equal ceil(log2(WIDTH)), minimum 1
STATE_OFFSET, 0, index of the current owner this instance assumes; range 0..WIDTH-1
REGISTER_OUTPUT, 0, 0 = state is purely combinational from request; nonzero = state is registered on clk

Ports:
clk  in  1  system clock; used only when REGISTER_OUTPUT != 0
srst  in  1  synchronous reset, active-high; used only when REGISTER_OUTPUT != 0
request  in  WIDTH  per-port request, bit i = port i requesting
state  out  LOG2_WIDTH  index of the next port to grant

Behaviour:
- Search order is circular: (STATE_OFFSET+1) mod WIDTH, (STATE_OFFSET+2) mod WIDTH, ..., (STATE_OFFSET+WIDTH) mod WIDTH.
  - The current owner STATE_OFFSET is therefore checked last.
- state = the first index in that order whose request bit is 1.
- No request asserted (request == 0): state = STATE_OFFSET (hold owner).
- Only the owner requesting: state = STATE_OFFSET (owner keeps access).
- Wrap-around is modulo WIDTH, not modulo 2^LOG2_WIDTH. Output is never >= WIDTH.
- Index encoding: unsigned binary, zero-extended to LOG2_WIDTH.
- REGISTER_OUTPUT == 0:
  - Purely combinational, zero latency.
  - clk and srst are ignored.
  - No internal state; output settles in the same cycle request changes.
- REGISTER_OUTPUT != 0:
  - state is updated on rising clk with the combinational result; 1-cycle latency.
  - srst = 1 at a rising edge: state <= STATE_OFFSET. srst has priority over request.
  - Reset mid-operation discards any pending result; the first valid result appears on the edge after srst deasserts.
  - Before the first reset, state is undefined.
- Result must be identical for every request pattern regardless of REGISTER_OUTPUT, apart from latency.
- Any correct implementation is acceptable (rotate-then-priority-encode, or a loop over offsets 1..WIDTH). No X on the output for fully known inputs.
- Integration contract: an arbiter storing state S and selecting instance S each cycle serves requesting ports fairly. Each active requester is served at least once every WIDTH cycles.

Test Plan:
- WIDTH=4, STATE_OFFSET=0, request=4'b0000 -> state=0; request=4'b0001 -> state=0; request=4'b1111 -> state=1.
- WIDTH=4, STATE_OFFSET=2, request=4'b0011 -> state=0 (wrap past 3); request=4'b1000 -> state=3; request=4'b0100 -> state=2.
- WIDTH=4, STATE_OFFSET=3, request=4'b1010 -> state=1; request=4'b1000 -> state=3. Exhaustive sweep of all 16 requests x 4 offsets against a behavioural model matches.
- WIDTH=3, LOG2_WIDTH=2, STATE_OFFSET=2, request=3'b010 -> state=1; request=3'b100 -> state=2; state is never 3 for any request.
- REGISTER_OUTPUT=1, WIDTH=4, STATE_OFFSET=1:
  - srst=1 for 2 cycles -> state=1.
  - Release, drive request=4'b0001 -> state=0 one edge later.
  - Assert srst with request still 4'b0001 -> state=1 next edge.
- Ring of 4 instances (WIDTH=4) feeding a registered state mux, all requests held at 1 -> state sequence 0,1,2,3,0,...
  - Drop request[2] -> sequence 0,1,3,0,...
